// File: rtl/decompress_unpacker.sv
// Sequential 8-lane unpacker: one variable-length word per cycle, MSB first.
// Optional padding check enabled by defining DECOMP_PADCHECK_EN.
module decompress_unpacker #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 2,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wrtEn,
   input  logic [DATA_WIDTH*8-1:0] dataIn,
   input  logic [TAG_WIDTH*8-1:0]  tagIn,
   output logic                    inReady,
   output logic [DATA_WIDTH*8-1:0] dataOut,
   output logic                    outValid,
   input  logic                    rdEn,
   output logic                    errOut
);

   localparam int BW = DATA_WIDTH * 8;
   localparam int QW = DATA_WIDTH / 4;
   localparam int HW = DATA_WIDTH / 2;

   typedef enum logic [1:0] {IDLE, UNPACK, DONE} state_t;

   state_t                 state_q, state_d;
   logic [BW-1:0]          shift_q, shift_d;
   logic [TAG_WIDTH*8-1:0] tag_q, tag_d;
   logic [CNT_WIDTH-1:0]   idx_q, idx_d;
   logic [BW-1:0]          data_q, data_d;
   logic                   valid_q, valid_d;

   logic                   accept;
   logic [TAG_WIDTH-1:0]   cur_tag;
   logic [DATA_WIDTH-1:0]  top;
   logic [DATA_WIDTH-1:0]  word;
   logic [BW-1:0]          shift_nx;
   logic                   last_lane;

   assign inReady   = (state_q == IDLE) || ((state_q == DONE) && rdEn);
   assign accept    = wrtEn && inReady;
   assign top       = shift_q[BW-1 -: DATA_WIDTH];
   assign last_lane = (state_q == UNPACK) && (idx_q == '0);
   assign dataOut   = data_q;
   assign outValid  = valid_q;

   always_comb begin
      cur_tag = '0;
      for (int i = 0; i < 8; i++) begin
         if (idx_q == CNT_WIDTH'(i)) cur_tag = tag_q[i*TAG_WIDTH +: TAG_WIDTH];
      end
   end

   // Field sits at the top of the shift register; shorter fields sign-extend.
   always_comb begin
      word     = '0;
      shift_nx = shift_q;
      unique case (cur_tag)
         2'd1: begin
            word     = {{(DATA_WIDTH-QW){top[DATA_WIDTH-1]}}, top[DATA_WIDTH-1 -: QW]};
            shift_nx = shift_q << QW;
         end
         2'd2: begin
            word     = {{(DATA_WIDTH-HW){top[DATA_WIDTH-1]}}, top[DATA_WIDTH-1 -: HW]};
            shift_nx = shift_q << HW;
         end
         2'd3: begin
            word     = top;
            shift_nx = shift_q << DATA_WIDTH;
         end
         default: begin
            word     = '0;
            shift_nx = shift_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      tag_d   = tag_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      unique case (state_q)
         UNPACK: begin
            for (int i = 0; i < 8; i++) begin
               if (idx_q == CNT_WIDTH'(i)) data_d[i*DATA_WIDTH +: DATA_WIDTH] = word;
            end
            shift_d = shift_nx;
            idx_d   = idx_q - CNT_WIDTH'(1);
            if (last_lane) begin
               state_d = DONE;
               valid_d = 1'b1;
            end
         end
         DONE: begin
            if (rdEn) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: ;
      endcase
      if (accept) begin
         state_d = UNPACK;
         shift_d = dataIn;
         tag_d   = tagIn;
         idx_d   = CNT_WIDTH'(7);
         data_d  = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         tag_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`ifdef DECOMP_PADCHECK_EN
   logic err_q, err_d;

   // Residual bits left after lane 0 are padding and must be zero.
   always_comb begin
      err_d = err_q;
      if (last_lane) err_d = |shift_nx;
      else if ((state_q == DONE) && rdEn) err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign errOut = err_q;
`else
   assign errOut = 1'b0;
`endif

endmodule

// File: tb/tb_decompress_unpacker.sv
// Directed bench for decompress_unpacker with hand-computed blocks.
module tb_decompress_unpacker;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          wrtEn;
   logic [DW*8-1:0] dataIn;
   logic [15:0]   tagIn;
   logic          inReady;
   logic [DW*8-1:0] dataOut;
   logic          outValid;
   logic          rdEn;
   logic          errOut;

   int n_tests = 0;
   int n_fail  = 0;

   decompress_unpacker #(.DATA_WIDTH(DW), .TAG_WIDTH(2), .CNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .wrtEn(wrtEn), .dataIn(dataIn),
      .tagIn(tagIn), .inReady(inReady), .dataOut(dataOut),
      .outValid(outValid), .rdEn(rdEn), .errOut(errOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_block(input string tag, input logic [255:0] din,
                            input logic [15:0] tin, input logic with_rd,
                            input logic [255:0] exp, input logic exp_err);
      logic early;
      logic busy_rdy;
      early    = 1'b0;
      busy_rdy = 1'b0;
      wrtEn  = 1'b1;
      dataIn = din;
      tagIn  = tin;
      rdEn   = with_rd;
      tick();
      wrtEn  = 1'b0;
      rdEn   = 1'b0;
      dataIn = {8{$urandom}};
      tagIn  = 16'($urandom);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         else       tick();
         if (k < 8) begin
            early    = early | outValid;
            busy_rdy = busy_rdy | inReady;
         end
      end
      check({tag, "_early_valid"}, 256'(early), 256'(0));
      check({tag, "_busy_ready"}, 256'(busy_rdy), 256'(0));
      check({tag, "_valid"}, 256'(outValid), 256'(1));
      check({tag, "_data"}, dataOut, exp);
      check({tag, "_err"}, 256'(errOut), 256'(exp_err));
   endtask

   task automatic consume(input string tag);
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      check({tag, "_cons_valid"}, 256'(outValid), 256'(0));
      check({tag, "_cons_ready"}, 256'(inReady), 256'(1));
      check({tag, "_cons_err"}, 256'(errOut), 256'(0));
   endtask

   logic [255:0] blk_raw;
   logic [255:0] blk_mix_in;
   logic [255:0] blk_mix_exp;
   logic [255:0] blk_pad_in;
   logic [255:0] blk_pad_exp;
   logic         pad_err;

   initial begin
      blk_raw = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
      blk_mix_in  = {24'h801234, 232'd0};
      blk_mix_exp = {32'hFFFFFF80, 32'h00001234, 192'd0};
      blk_pad_in  = {64'h01FF_7F80_0012_3456, 191'd0, 1'b1};
      blk_pad_exp = {32'h00000001, 32'hFFFFFFFF, 32'h0000007F, 32'hFFFFFF80,
                     32'h00000000, 32'h00000012, 32'h00000034, 32'h00000056};
`ifdef DECOMP_PADCHECK_EN
      pad_err = 1'b1;
`else
      pad_err = 1'b0;
`endif

      reset  = 1'b1;
      wrtEn  = 1'b0;
      rdEn   = 1'b0;
      dataIn = '0;
      tagIn  = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_valid", 256'(outValid), 256'(0));
      check("rst_data", dataOut, 256'(0));
      check("rst_err", 256'(errOut), 256'(0));
      check("rst_ready", 256'(inReady), 256'(1));

      run_block("raw", blk_raw, 16'hFFFF, 1'b0, blk_raw, 1'b0);
      consume("raw");

      run_block("zero", 256'd0, 16'h0000, 1'b0, 256'd0, 1'b0);
      consume("zero");

      run_block("mix", blk_mix_in, 16'h6000, 1'b0, blk_mix_exp, 1'b0);

      // Held in DONE: outputs stable, wrtEn ignored
      for (int k = 0; k < 5; k++) begin
         wrtEn  = 1'b1;
         dataIn = {8{$urandom}};
         tagIn  = 16'hFFFF;
         tick();
         check("bp_valid", 256'(outValid), 256'(1));
         check("bp_data", dataOut, blk_mix_exp);
         check("bp_ready", 256'(inReady), 256'(0));
      end
      wrtEn = 1'b0;

      run_block("b2b", blk_raw, 16'hFFFF, 1'b1, blk_raw, 1'b0);
      consume("b2b");

      // Reset while lane 4 is next
      wrtEn  = 1'b1;
      dataIn = blk_raw;
      tagIn  = 16'hFFFF;
      tick();
      wrtEn = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      wrtEn = 1'b1;
      rdEn  = 1'b1;
      tick();
      reset = 1'b0;
      wrtEn = 1'b0;
      rdEn  = 1'b0;
      check("mid_rst_valid", 256'(outValid), 256'(0));
      check("mid_rst_data", dataOut, 256'(0));
      check("mid_rst_ready", 256'(inReady), 256'(1));

      run_block("post_rst", blk_mix_in, 16'h6000, 1'b0, blk_mix_exp, 1'b0);
      consume("post_rst");

      run_block("pad", blk_pad_in, 16'h5555, 1'b0, blk_pad_exp, pad_err);
      consume("pad");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
